// File: rtl/fsk_tx_scheduler.sv
// Shares one FSK modulator between two word sources, loading one word per WORD_CYCLES-clock slot.
// Optional macro FSK_SCHED_FIXED_PRIO_EN: req0 always wins a tie (default build uses round-robin).
module fsk_tx_scheduler #(
   parameter int unsigned   DW          = 9,
   parameter int unsigned   WORD_CYCLES = 144,
   parameter logic [DW-1:0] IDLE_WORD   = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic [DW-1:0] fsk_datain,
   output logic          word_strobe,
   output logic          grant_id,
   output logic          busy,
   output logic [15:0]   words_sent
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [15:0] LAST_CNT = 16'(WORD_CYCLES - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        at_end;
   logic        boundary;
   logic        drain_end;
   logic        grant1;
   logic        xfer;

   assign at_end = (cnt == LAST_CNT);

`ifdef FSK_SCHED_FIXED_PRIO_EN
   assign grant1 = req1_valid & ~req0_valid;
`else
   logic last;

   // On a tie the requester opposite the previous tie winner is served.
   assign grant1 = req1_valid & (~req0_valid | ~last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last <= 1'b1;
      else if (boundary && req0_valid && req1_valid)
         last <= grant1;
   end
`endif

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      boundary  = 1'b0;
      drain_end = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (enable) begin
               boundary  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            cnt_nxt = at_end ? '0 : cnt + 16'd1;
            if (!enable) begin
               drain_end = at_end;
               state_nxt = at_end ? IDLE : DRAIN;
            end else begin
               boundary = at_end;
            end
         end
         DRAIN: begin
            cnt_nxt = at_end ? '0 : cnt + 16'd1;
            if (at_end) begin
               drain_end = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Readies are gated by reset so no requester sees an acceptance while the block is held in reset.
   assign req0_ready  = boundary & reset & req0_valid & ~grant1;
   assign req1_ready  = boundary & reset & grant1;
   assign xfer        = req0_ready | req1_ready;
   assign word_strobe = (state == RUN) && (cnt == '0);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsk_datain <= IDLE_WORD;
         grant_id   <= 1'b0;
         busy       <= 1'b0;
         words_sent <= '0;
      end else if (xfer) begin
         fsk_datain <= grant1 ? req1_data : req0_data;
         grant_id   <= grant1;
         busy       <= 1'b1;
         words_sent <= words_sent + 16'd1;
      end else if (boundary || drain_end) begin
         fsk_datain <= IDLE_WORD;
         busy       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Self-checking bench for fsk_tx_scheduler: expected slot contents are queued when stimulus is
// driven and popped/compared by a monitor on every word_strobe.
module tb_fsk_tx_scheduler;

   localparam int DW = 9;
   localparam int WC = 144;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          gid;
      logic          busy;
   } slot_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          req0_valid;
   logic [DW-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [DW-1:0] req1_data;
   logic          req1_ready;
   logic [DW-1:0] fsk_datain;
   logic          word_strobe;
   logic          grant_id;
   logic          busy;
   logic [15:0]   words_sent;

   int    checks = 0;
   int    errors = 0;
   slot_t exp_q[$];

   fsk_tx_scheduler #(.DW(DW), .WORD_CYCLES(WC), .IDLE_WORD(9'h000)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .fsk_datain (fsk_datain),
      .word_strobe(word_strobe),
      .grant_id   (grant_id),
      .busy       (busy),
      .words_sent (words_sent)
   );

   always #5 clk = ~clk;

   function automatic slot_t mk(input logic [DW-1:0] d, input logic g, input logic b);
      slot_t s;
      s.data = d;
      s.gid  = g;
      s.busy = b;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard: each strobe must present the oldest queued slot.
   always @(posedge clk) begin : sb_monitor
      slot_t e;
      #1;
      if (reset && word_strobe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_strobe: got data %h gid %b busy %b, expected no strobe",
                     fsk_datain, grant_id, busy);
         end else begin
            e = exp_q.pop_front();
            if ({fsk_datain, grant_id, busy} !== e) begin
               errors++;
               $display("FAIL sb_slot: got data %h gid %b busy %b, expected data %h gid %b busy %b",
                        fsk_datain, grant_id, busy, e.data, e.gid, e.busy);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0;
      req0_valid = 1'b0; req0_data = '0;
      req1_valid = 1'b0; req1_data = '0;
      #3;
      checks++; if (fsk_datain !== 9'h000) begin errors++; $display("FAIL rst_datain: got %h expected 000", fsk_datain); end
      checks++; if (word_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", word_strobe); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b expected 0", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (words_sent !== 16'h0000) begin errors++; $display("FAIL rst_words: got %h expected 0000", words_sent); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {req0_ready, req1_ready}); end
      tick(); tick();
      reset = 1'b1;
      tick(); tick();
   endtask

   task automatic test_idle_slots();
      int nstrobe = 0, first = -1, prev = -1, bad_gap = 0, bad_out = 0;
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(9'h000, 1'b0, 1'b0));
      enable = 1'b1;
      for (int t = 1; t <= 2*WC + 1; t++) begin
         tick();
         if (word_strobe === 1'b1) begin
            if (prev >= 0 && t - prev != WC) bad_gap++;
            if (first < 0) first = t;
            prev = t;
            nstrobe++;
         end
         if (busy !== 1'b0 || fsk_datain !== 9'h000 || words_sent !== 16'h0000 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) bad_out++;
      end
      checks++; if (first !== 1) begin errors++; $display("FAIL idle_first_strobe: got cycle %0d expected 1", first); end
      checks++; if (nstrobe !== 3) begin errors++; $display("FAIL idle_strobe_count: got %0d expected 3", nstrobe); end
      checks++; if (bad_gap !== 0) begin errors++; $display("FAIL idle_strobe_gap: got %0d bad gaps expected 0", bad_gap); end
      checks++; if (bad_out !== 0) begin errors++; $display("FAIL idle_outputs: got %0d bad cycles expected 0", bad_out); end
   endtask

   task automatic test_single();
      logic [15:0]   ws0;
      logic [DW-1:0] hold;
      int bad_hold = 0, bad_ready = 0;
      ws0 = words_sent;
      req0_valid = 1'b1; req0_data = 9'h0A5;
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(9'h0A5, 1'b0, 1'b1));
      for (int s = 0; s < 3; s++) begin
         hold = fsk_datain;
         for (int t = 1; t <= WC; t++) begin
            tick();
            if (t < WC && (word_strobe !== 1'b0 || fsk_datain !== hold)) bad_hold++;
            if (req0_ready !== ((t == WC-1) ? 1'b1 : 1'b0) || req1_ready !== 1'b0) bad_ready++;
         end
         checks++; if (word_strobe !== 1'b1) begin errors++; $display("FAIL single_strobe: slot %0d got %b expected 1", s, word_strobe); end
         checks++;
         if (words_sent !== ws0 + 16'(s + 1)) begin
            errors++; $display("FAIL single_words: slot %0d got %h expected %h", s, words_sent, ws0 + 16'(s + 1));
         end
      end
      checks++; if (bad_hold !== 0) begin errors++; $display("FAIL single_hold: got %0d unstable cycles expected 0", bad_hold); end
      checks++; if (bad_ready !== 0) begin errors++; $display("FAIL single_ready: got %0d bad ready cycles expected 0", bad_ready); end
      req0_valid = 1'b0;
   endtask

   task automatic test_both();
`ifdef FSK_SCHED_FIXED_PRIO_EN
      logic [3:0] gseq = 4'b0000;
`else
      logic [3:0] gseq = 4'b1010;
`endif
      int bad_ready = 0;
      req0_valid = 1'b1; req0_data = 9'h011;
      req1_valid = 1'b1; req1_data = 9'h122;
      for (int s = 0; s < 4; s++)
         exp_q.push_back(mk(gseq[s] ? 9'h122 : 9'h011, gseq[s], 1'b1));
      for (int s = 0; s < 4; s++) begin
         for (int t = 1; t <= WC; t++) begin
            tick();
            if (t == WC-1) begin
               if (req0_ready !== ~gseq[s] || req1_ready !== gseq[s]) bad_ready++;
            end else if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
               bad_ready++;
            end
         end
         checks++; if (grant_id !== gseq[s]) begin errors++; $display("FAIL both_grant: slot %0d got %b expected %b", s, grant_id, gseq[s]); end
      end
      checks++; if (bad_ready !== 0) begin errors++; $display("FAIL both_ready: got %0d bad ready cycles expected 0", bad_ready); end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_drain();
      logic [15:0] ws0;
      int bad_run = 0, bad_idle = 0;
      req1_valid = 1'b1; req1_data = 9'h1C3;
      exp_q.push_back(mk(9'h1C3, 1'b1, 1'b1));
      for (int t = 1; t <= WC; t++) tick();
      ws0 = words_sent;
      for (int t = 1; t <= WC; t++) begin
         tick();
         if (t == 50) enable = 1'b0;
         if (t < WC && (fsk_datain !== 9'h1C3 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)) bad_run++;
      end
      checks++; if (fsk_datain !== 9'h000) begin errors++; $display("FAIL drain_idle_word: got %h expected 000", fsk_datain); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b expected 0", busy); end
      checks++; if (word_strobe !== 1'b0) begin errors++; $display("FAIL drain_strobe: got %b expected 0", word_strobe); end
      for (int t = 0; t < 5; t++) begin
         tick();
         if (fsk_datain !== 9'h000 || word_strobe !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad_idle++;
      end
      checks++; if (bad_run !== 0) begin errors++; $display("FAIL drain_hold: got %0d bad cycles expected 0", bad_run); end
      checks++; if (bad_idle !== 0) begin errors++; $display("FAIL drain_parked: got %0d bad cycles expected 0", bad_idle); end
      checks++; if (words_sent !== ws0) begin errors++; $display("FAIL drain_words: got %h expected %h", words_sent, ws0); end
      exp_q.push_back(mk(9'h1C3, 1'b1, 1'b1));
      enable = 1'b1;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL restart_ready: got %b expected 01", {req0_ready, req1_ready}); end
      tick();
      checks++; if (word_strobe !== 1'b1) begin errors++; $display("FAIL restart_strobe: got %b expected 1", word_strobe); end
      req1_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      req0_valid = 1'b1; req0_data = 9'h0A5;
      exp_q.push_back(mk(9'h0A5, 1'b0, 1'b1));
      for (int t = 1; t <= WC; t++) tick();
      req0_valid = 1'b0;
      for (int t = 1; t <= 70; t++) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
      reset = 1'b0; enable = 1'b0;
      exp_q.delete();
      #1;
      checks++; if (fsk_datain !== 9'h000) begin errors++; $display("FAIL midrst_datain: got %h expected 000", fsk_datain); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (words_sent !== 16'h0000) begin errors++; $display("FAIL midrst_words: got %h expected 0000", words_sent); end
      checks++; if ({grant_id, word_strobe} !== 2'b00) begin errors++; $display("FAIL midrst_grant_strobe: got %b expected 00", {grant_id, word_strobe}); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_wrap();
      force dut.words_sent = 16'hFFFF;
      #1;
      release dut.words_sent;
      #1;
      checks++; if (words_sent !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", words_sent); end
      req0_valid = 1'b1; req0_data = 9'h155;
      req1_valid = 1'b1; req1_data = 9'h0AA;
      exp_q.push_back(mk(9'h155, 1'b0, 1'b1));
      enable = 1'b1;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL wrap_first_tie: got %b expected 10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++; if (words_sent !== 16'h0000) begin errors++; $display("FAIL wrap_words: got %h expected 0000", words_sent); end
      tick();
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_slots();
      test_single();
      test_both();
      test_drain();
      test_reset_mid();
      test_wrap();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d queued slots expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
